// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers message bytes and feeds them to the hash core with start/End_Of_File framing
module hash_msg_feeder #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             in_ready,
  output logic             start,
  output logic             F_dr,
  output logic [7:0]       M_out,
  input  logic             F_rtr,
  output logic             End_Of_File,
  input  logic             H_ready,
  output logic [LEN_W-1:0] msg_len,
  output logic             len_ovf
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, EOF_WAIT} state_t;
  state_t state;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [LEN_W-1:0] byte_cnt, cnt_inc;
  logic ovf, ovf_inc, fifo_empty, push, pop, data_pop, mark_pop;
  assign fifo_empty = count == '0;
  assign in_ready = count != (AW+1)'(DEPTH);
  assign push = in_valid & in_ready;
  assign M_out = fifo_empty ? 8'h00 : mem[rd_ptr][7:0];
  assign F_dr = state == ACTIVE & !fifo_empty & !mem[rd_ptr][9];
  assign data_pop = F_dr & F_rtr;
  // zero-length markers are consumed here; the core never sees them
  assign mark_pop = state == ACTIVE & !fifo_empty & mem[rd_ptr][9];
  assign pop = data_pop | mark_pop;
  assign cnt_inc = &byte_cnt ? byte_cnt : byte_cnt + 1'b1;
  assign ovf_inc = ovf | &byte_cnt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_empty, in_last | in_empty, in_empty ? 8'h00 : in_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      start <= 1'b0;
      End_Of_File <= 1'b0;
      byte_cnt <= '0;
      ovf <= 1'b0;
      msg_len <= '0;
      len_ovf <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: if (!fifo_empty) begin
          state <= ACTIVE;
          start <= 1'b1;
          byte_cnt <= '0;
          ovf <= 1'b0;
        end
        ACTIVE: if (mark_pop) begin
          state <= EOF_WAIT;
          End_Of_File <= 1'b1;
          msg_len <= '0;
          len_ovf <= 1'b0;
        end else if (data_pop) begin
          byte_cnt <= cnt_inc;
          ovf <= ovf_inc;
          if (mem[rd_ptr][8]) begin
            state <= EOF_WAIT;
            End_Of_File <= 1'b1;
            msg_len <= cnt_inc;
            len_ovf <= ovf_inc;
          end
        end
        EOF_WAIT: if (H_ready) begin
          state <= IDLE;
          End_Of_File <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder: scoreboard bench; driver queues expected bytes/lengths, negedge monitor checks them
module tb_hash_msg_feeder;
  localparam int DEPTH = 8;
  localparam int LEN_W = 4;
  localparam int MAXV = (1 << LEN_W) - 1;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, in_empty = 0, F_rtr = 0, H_ready = 0;
  logic [7:0] in_data = 0, M_out;
  logic in_ready, start, F_dr, End_Of_File, len_ovf;
  logic [LEN_W-1:0] msg_len;
  int total = 0, bad = 0, cyc = 0, hr_cyc = -100, last_gap = 0, starts = 0, msgs = 0;
  int frtr_mode = 1, hr_delay = -1, hr_d = 0;
  bit mon_on = 0, eof_prev = 0, hr_pend = 0, gap_on = 0;
  logic [7:0] byte_q[$];
  logic [LEN_W:0] len_q[$];

  hash_msg_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_empty(in_empty), .in_ready(in_ready), .start(start), .F_dr(F_dr), .M_out(M_out),
    .F_rtr(F_rtr), .End_Of_File(End_Of_File), .H_ready(H_ready), .msg_len(msg_len), .len_ovf(len_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_on && rst_n) begin
      check("fdr_eof_exclusive", {31'd0, F_dr & End_Of_File}, 0);
      if (F_dr && F_rtr) begin
        if (byte_q.size() == 0) check("unexpected_pop_qsize", byte_q.size(), 1);
        else check("m_out", {24'd0, M_out}, {24'd0, byte_q.pop_front()});
      end
      if (End_Of_File && !eof_prev) begin
        if (len_q.size() == 0) check("unexpected_eof_qsize", len_q.size(), 1);
        else check("ovf_len", {27'd0, len_ovf, msg_len}, {27'd0, len_q.pop_front()});
      end
      if (hr_pend) begin
        check("eof_fall", {31'd0, End_Of_File}, 0);
        hr_cyc = cyc - 1;
      end
      if (start) begin
        starts++;
        last_gap = cyc - hr_cyc;
      end
    end
    eof_prev = End_Of_File;
    hr_pend = H_ready && End_Of_File;
  end

  initial forever begin
    @(posedge clk);
    #1;
    F_rtr = frtr_mode == 2 ? 1'($urandom_range(0, 1)) : frtr_mode == 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (End_Of_File) begin
      hr_d = hr_delay >= 0 ? hr_delay : int'($urandom_range(0, 6));
      repeat (hr_d) begin
        @(posedge clk);
        #1;
      end
      H_ready = 1;
      @(posedge clk);
      #1;
      H_ready = 0;
    end
  end

  task automatic push_entry(logic [7:0] d, logic l, logic e);
    logic rdy;
    int t = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    in_empty = e;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 2000);
    if (!rdy) check("push_timeout", t, 0);
    in_valid = 0;
    if (gap_on) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(int n, int base, bit rnd);
    msgs++;
    len_q.push_back(n > MAXV ? {1'b1, LEN_W'(MAXV)} : {1'b0, LEN_W'(n)});
    if (n == 0) push_entry(8'($urandom), 0, 1);
    else for (int i = 0; i < n; i++) begin
      logic [7:0] d = rnd ? 8'($urandom) : 8'(base + i);
      byte_q.push_back(d);
      push_entry(d, i == n - 1, 0);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((byte_q.size() != 0 || len_q.size() != 0 || End_Of_File) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", byte_q.size() + len_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", {31'd0, start}, 0);
    check("rst_fdr", {31'd0, F_dr}, 0);
    check("rst_eof", {31'd0, End_Of_File}, 0);
    check("rst_len", {28'd0, msg_len}, 0);
    check("rst_ovf", {31'd0, len_ovf}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1;
    frtr_mode = 1;
    push_entry(8'h11, 0, 0);
    push_entry(8'h22, 0, 0);
    push_entry(8'h33, 0, 0);
    #2 rst_n = 0;
    #1;
    check("midrst_start", {31'd0, start}, 0);
    check("midrst_fdr", {31'd0, F_dr}, 0);
    check("midrst_eof", {31'd0, End_Of_File}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 1);
    check("midrst_len", {27'd0, len_ovf, msg_len}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      check("postrst_start", {31'd0, start}, 0);
      check("postrst_eof", {31'd0, End_Of_File}, 0);
    end
    @(posedge clk);
    #1;
    mon_on = 1;
    send_msg(3, 'h61, 0);
    wait_drain();
    check("single_len", {28'd0, msg_len}, 3);
    send_msg(0, 0, 0);
    wait_drain();
    check("empty_len", {27'd0, len_ovf, msg_len}, 0);
    frtr_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    msgs++;
    len_q.push_back({1'b0, LEN_W'(11)});
    for (int i = 0; i < DEPTH; i++) begin
      byte_q.push_back(8'(i));
      push_entry(8'(i), 0, 0);
    end
    check("full_in_ready", {31'd0, in_ready}, 0);
    frtr_mode = 1;
    for (int i = DEPTH; i < 11; i++) begin
      byte_q.push_back(8'(i));
      push_entry(8'(i), i == 10, 0);
    end
    wait_drain();
    hr_delay = 10;
    send_msg(2, 'hA0, 0);
    send_msg(1, 'hB0, 0);
    wait_drain();
    check("b2b_start_gap", last_gap, 2);
    check("b2b_len", {28'd0, msg_len}, 1);
    hr_delay = -1;
    frtr_mode = 2;
    send_msg(20, 0, 1);
    send_msg(2, 0, 1);
    wait_drain();
    check("sat_then_small", {27'd0, len_ovf, msg_len}, {27'd0, 1'b0, LEN_W'(2)});
    gap_on = 1;
    for (int m = 0; m < 30; m++) send_msg($urandom_range(0, 6) == 0 ? 0 : int'($urandom_range(1, 20)), 0, 1);
    wait_drain();
    check("start_count", starts, msgs);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
